// File: rtl/vector_seq_ctrl_pkg.sv
// ============================================================================
//  Module : vector_seq_ctrl_pkg
//  Brief  : Opcodes, MemMux selects, state encoding and strobe decode for the
//           vector sequencing sub-controller.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package vector_seq_ctrl_pkg;

  localparam int LANES_DEF = 4;
  localparam int CNT_W_DEF = 3;
  localparam int OP_W      = 2;
  localparam int MEMIN_W   = 3;

  localparam logic [OP_W-1:0] OP_VLD  = 2'b00;
  localparam logic [OP_W-1:0] OP_VST  = 2'b01;
  localparam logic [OP_W-1:0] OP_VADD = 2'b10;
  localparam logic [OP_W-1:0] OP_ILL  = 2'b11;

  localparam logic [MEMIN_W-1:0] MEMIN_LANE0 = 3'd0;
  localparam logic [MEMIN_W-1:0] MEMIN_LANE1 = 3'd1;
  localparam logic [MEMIN_W-1:0] MEMIN_LANE2 = 3'd2;
  localparam logic [MEMIN_W-1:0] MEMIN_LANE3 = 3'd3;
  localparam logic [MEMIN_W-1:0] MEMIN_R1    = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_VLD     = 4'd1,
    S_VLD_WB  = 4'd2,
    S_VST_X   = 4'd3,
    S_VST     = 4'd4,
    S_VADD_X  = 4'd5,
    S_VADD_T  = 4'd6,
    S_VADD_WB = 4'd7,
    S_DONE    = 4'd8
  } state_e;

  typedef struct packed {
    logic               busy;
    logic               done;
    logic               mem_read;
    logic               mem_write;
    logic               addr_sel;
    logic [MEMIN_W-1:0] mem_in;
    logic               r2_load;
    logic               r2_sel;
    logic               x1_load;
    logic               x2_load;
    logic               vout_sel;
    logic [3:0]         t_ld;
    logic               vrf_write;
  } ctrl_t;

  // Strobes for one state/counter point; per-lane VLD captures are OR-ed in
  // by the caller from the lane decoder.
  function automatic ctrl_t ctrl_decode(state_e s, logic k_zero, logic k_issue,
                                        logic [1:0] lane);
    ctrl_t c;
    c          = '0;
    c.busy     = (s != S_IDLE);
    c.addr_sel = (s == S_IDLE);
    c.mem_in   = MEMIN_R1;
    case (s)
      S_VLD: begin
        c.mem_read = k_issue;
        c.r2_load  = k_issue;
        c.r2_sel   = k_issue;
        c.vout_sel = !k_zero;
      end
      S_VLD_WB, S_VADD_WB: c.vrf_write = 1'b1;
      S_VST_X: c.x1_load = 1'b1;
      S_VST: begin
        c.mem_write = 1'b1;
        c.r2_load   = 1'b1;
        c.r2_sel    = 1'b1;
        case (lane)
          2'd0:    c.mem_in = MEMIN_LANE0;
          2'd1:    c.mem_in = MEMIN_LANE1;
          2'd2:    c.mem_in = MEMIN_LANE2;
          default: c.mem_in = MEMIN_LANE3;
        endcase
      end
      S_VADD_X: begin
        c.x1_load = 1'b1;
        c.x2_load = 1'b1;
      end
      S_VADD_T: begin
        c.t_ld     = 4'b1111;
        c.vout_sel = 1'b0;
      end
      S_DONE: c.done = k_zero;
      default: ;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/vector_seq_ctrl_if.sv
// ============================================================================
//  Module : vector_seq_ctrl_if
//  Brief  : Handshake from the main FSM plus the vector datapath/memory strobes.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface vector_seq_ctrl_if;
  import vector_seq_ctrl_pkg::*;

  logic               start;
  logic [OP_W-1:0]    op;
  logic               busy;
  logic               done;
  logic               mem_read;
  logic               mem_write;
  logic               addr_sel;
  logic [MEMIN_W-1:0] mem_in;
  logic               r2_load;
  logic               r2_sel;
  logic               x1_load;
  logic               x2_load;
  logic               vout_sel;
  logic [3:0]         t_ld;
  logic               vrf_write;

  modport master (
    output start, op,
    input  busy, done, mem_read, mem_write, addr_sel, mem_in, r2_load, r2_sel,
           x1_load, x2_load, vout_sel, t_ld, vrf_write
  );

  modport slave (
    input  start, op,
    output busy, done, mem_read, mem_write, addr_sel, mem_in, r2_load, r2_sel,
           x1_load, x2_load, vout_sel, t_ld, vrf_write
  );

endinterface

`default_nettype wire

// File: rtl/vector_seq_ctrl_lane_decode.sv
// ============================================================================
//  Module : vector_seq_ctrl_lane_decode
//  Brief  : 2-bit lane index to 4-bit one-hot T-register load, gated by enable.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vector_seq_ctrl_lane_decode (
  input  logic [1:0] lane_i,
  input  logic       en_i,
  output logic [3:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[lane_i] = 1'b1;
  end

endmodule

`default_nettype wire

// File: rtl/vector_seq_ctrl.sv
// ============================================================================
//  Module : vector_seq_ctrl
//  Brief  : Sequences per-lane strobes for VLD / VST / VADD and returns done.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vector_seq_ctrl
  import vector_seq_ctrl_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  vector_seq_ctrl_if.slave   bus
);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] VLD_LAST = CNT_W'(LANES);
  localparam logic [CNT_W-1:0] VST_LAST = CNT_W'(LANES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [3:0]       lane_hot;
  logic             lane_en;
  logic [1:0]       cap_lane;

  // An illegal op parks in DONE with the counter at one, so done still comes
  // a cycle later and no datapath strobe is ever raised.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          cnt_d = CNT_ZERO;
          case (bus.op)
            OP_VLD:  state_d = S_VLD;
            OP_VST:  state_d = S_VST_X;
            OP_VADD: state_d = S_VADD_X;
            OP_ILL: begin
              state_d = S_DONE;
              cnt_d   = CNT_ONE;
            end
            default: state_d = S_IDLE;
          endcase
        end
      end
      S_VLD: begin
        if (cnt_q == VLD_LAST) begin
          state_d = S_VLD_WB;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_VLD_WB: state_d = S_DONE;
      S_VST_X:  state_d = S_VST;
      S_VST: begin
        if (cnt_q == VST_LAST) begin
          state_d = S_DONE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_VADD_X:  state_d = S_VADD_T;
      S_VADD_T:  state_d = S_VADD_WB;
      S_VADD_WB: state_d = S_DONE;
      S_DONE: begin
        if (cnt_q != CNT_ZERO) cnt_d = cnt_q - CNT_ONE;
        else                   state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Lane k-1 is captured while lane k is being issued (one-cycle memory latency).
  assign lane_en  = (state_d == S_VLD) && (cnt_d != CNT_ZERO);
  assign cap_lane = 2'(cnt_d - CNT_ONE);

  vector_seq_ctrl_lane_decode u_lane_decode (
    .lane_i   (cap_lane),
    .en_i     (lane_en),
    .onehot_o (lane_hot)
  );

  always_comb begin
    ctrl_d      = ctrl_decode(state_d, cnt_d == CNT_ZERO, cnt_d < VLD_LAST, 2'(cnt_d));
    ctrl_d.t_ld = ctrl_d.t_ld | lane_hot;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= CNT_ZERO;
      ctrl_q  <= ctrl_decode(S_IDLE, 1'b1, 1'b1, 2'd0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ctrl_q  <= ctrl_d;
    end
  end

  assign bus.busy      = ctrl_q.busy;
  assign bus.done      = ctrl_q.done;
  assign bus.mem_read  = ctrl_q.mem_read;
  assign bus.mem_write = ctrl_q.mem_write;
  assign bus.addr_sel  = ctrl_q.addr_sel;
  assign bus.mem_in    = ctrl_q.mem_in;
  assign bus.r2_load   = ctrl_q.r2_load;
  assign bus.r2_sel    = ctrl_q.r2_sel;
  assign bus.x1_load   = ctrl_q.x1_load;
  assign bus.x2_load   = ctrl_q.x2_load;
  assign bus.vout_sel  = ctrl_q.vout_sel;
  assign bus.t_ld      = ctrl_q.t_ld;
  assign bus.vrf_write = ctrl_q.vrf_write;

endmodule

`default_nettype wire

// File: tb/tb_vector_seq_ctrl.sv
// ============================================================================
//  Module : tb_vector_seq_ctrl
//  Brief  : Drives vector_seq_ctrl against a byte-level model of the datapath.
//  Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vector_seq_ctrl;

  localparam logic [1:0] T_VLD = 2'b00, T_VST = 2'b01, T_VADD = 2'b10, T_ILL = 2'b11;
  localparam logic [17:0] IDLE_OUTS = {4'b0000, 1'b1, 3'd4, 5'b00000, 4'b0000, 1'b0};

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  vector_seq_ctrl_if bus ();

  vector_seq_ctrl #(.LANES(4), .CNT_W(3)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  wire [17:0] outs = {bus.busy, bus.done, bus.mem_read, bus.mem_write, bus.addr_sel,
                      bus.mem_in, bus.r2_load, bus.r2_sel, bus.x1_load, bus.x2_load,
                      bus.vout_sel, bus.t_ld, bus.vrf_write};

  // Datapath model: synchronous memory, R2, X1/X2, T lanes and a 4-entry VRF.
  logic [7:0]  mem [256];
  logic [7:0]  r2, q;
  logic [7:0]  r1 = 8'h5A;
  logic [31:0] x1, x2;
  logic [31:0] vrf [4];
  logic [7:0]  t [4];
  logic [1:0]  src1 = 2'd0, src2 = 2'd1, dst = 2'd2;
  int          pk_kind = 0;
  logic [7:0]  pk_addr = 8'h00;
  logic [31:0] pk_data = 32'h0;

  wire [7:0] addr = bus.addr_sel ? 8'h00 : r2;
  wire [7:0] wdat = (bus.mem_in < 3'd4) ? x1[8*bus.mem_in[1:0] +: 8] : r1;

  always @(posedge clock) begin
    if (pk_kind == 1) mem[pk_addr] <= pk_data[7:0];
    if (pk_kind == 2) r2 <= pk_data[7:0];
    if (pk_kind == 3) vrf[pk_addr[1:0]] <= pk_data;
    if (bus.mem_read)  q <= mem[addr];
    if (bus.mem_write) mem[addr] <= wdat;
    if (bus.r2_load)   r2 <= bus.r2_sel ? 8'(r2 + 8'd1) : r1;
    if (bus.x1_load)   x1 <= vrf[src1];
    if (bus.x2_load)   x2 <= vrf[src2];
    for (int k = 0; k < 4; k++)
      if (bus.t_ld[k]) t[k] <= bus.vout_sel ? q : 8'(x1[8*k +: 8] + x2[8*k +: 8]);
    if (bus.vrf_write) vrf[dst] <= {t[3], t[2], t[1], t[0]};
  end

  // Strobe counters and invariant violation counters.
  int rd_cnt = 0, wr_cnt = 0, tl_cnt = 0, vw_cnt = 0, dn_cnt = 0;
  int both_cnt = 0, memin_bad = 0, addr_bad = 0;

  always @(negedge clock) begin
    if (bus.mem_read)  rd_cnt <= rd_cnt + 1;
    if (bus.mem_write) wr_cnt <= wr_cnt + 1;
    tl_cnt <= tl_cnt + $countones(bus.t_ld);
    if (bus.vrf_write) vw_cnt <= vw_cnt + 1;
    if (bus.done)      dn_cnt <= dn_cnt + 1;
    if (bus.mem_read && bus.mem_write)       both_cnt  <= both_cnt + 1;
    if (!bus.mem_write && bus.mem_in != 3'd4) memin_bad <= memin_bad + 1;
    if (bus.busy == bus.addr_sel)            addr_bad  <= addr_bad + 1;
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic poke(input int kind, input logic [7:0] a, input logic [31:0] d);
    pk_kind = kind;
    pk_addr = a;
    pk_data = d;
    @(posedge clock);
    #1;
    pk_kind = 0;
    tick();
  endtask

  function automatic int exp_lat(input logic [1:0] op);
    case (op)
      T_VLD:   return 7;
      T_VST:   return 1 + 4 + 1;
      T_VADD:  return 4;
      default: return 2;
    endcase
  endfunction

  // {reads, writes, T-lane loads, vrf writes, done pulses}
  function automatic logic [39:0] exp_strobes(input logic [1:0] op);
    case (op)
      T_VLD:   return {8'd4, 8'd0, 8'd4, 8'd1, 8'd1};
      T_VST:   return {8'd0, 8'd4, 8'd0, 8'd0, 8'd1};
      T_VADD:  return {8'd0, 8'd0, 8'd4, 8'd1, 8'd1};
      default: return {8'd0, 8'd0, 8'd0, 8'd0, 8'd1};
    endcase
  endfunction

  // Issue one op; optionally re-pulse start at cycle repulse_at while busy.
  task automatic run_op(input logic [1:0] op, input int repulse_at,
                        output int lat, output logic [39:0] strobes);
    int rd0, wr0, tl0, vw0, dn0, bad, n;
    rd0 = rd_cnt; wr0 = wr_cnt; tl0 = tl_cnt; vw0 = vw_cnt; dn0 = dn_cnt;
    bad = 0;
    lat = -1;
    n   = 1;
    bus.op    = op;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    while (lat < 0 && n <= 40) begin
      if (!bus.busy) bad++;
      if (bus.done) lat = n;
      bus.start = (n == repulse_at);
      if (n == repulse_at) bus.op = $urandom_range(0, 3);
      tick();
      n++;
    end
    bus.start = 1'b0;
    tick();
    if (bus.busy || bus.done) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL busy_window op=%0d: %0d bad cycles, required 0", op, bad);
    end
    strobes = {8'(rd_cnt - rd0), 8'(wr_cnt - wr0), 8'(tl_cnt - tl0),
               8'(vw_cnt - vw0), 8'(dn_cnt - dn0)};
  endtask

  task automatic test_reset();
    int vw0;
    logic [31:0] keep;
    checks++;
    if (outs !== IDLE_OUTS) begin
      errors++;
      $display("FAIL reset_outputs: got %h, required %h", outs, IDLE_OUTS);
    end
    reset = 1'b0;
    tick();
    // Abort a VLD while lane 1 is being captured (k=2).
    dst = 2'd3;
    poke(3, 8'd3, 32'hCAFEF00D);
    keep = vrf[3];
    poke(2, 8'h00, 32'h40);
    vw0 = vw_cnt;
    bus.op = T_VLD;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    checks++;
    if (bus.t_ld !== 4'b0010 || !bus.mem_read) begin
      errors++;
      $display("FAIL vld_k2_strobes: got t_ld=%b rd=%b, required t_ld=0010 rd=1", bus.t_ld, bus.mem_read);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (outs !== IDLE_OUTS) begin
      errors++;
      $display("FAIL async_reset_outputs: got %h, required %h", outs, IDLE_OUTS);
    end
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (outs !== IDLE_OUTS || vw_cnt != vw0 || vrf[3] !== keep) begin
      errors++;
      $display("FAIL reset_abort: got outs=%h vrf_writes=%0d vrf3=%h, required outs=%h vrf_writes=0 vrf3=%h",
               outs, vw_cnt - vw0, vrf[3], IDLE_OUTS, keep);
    end
  endtask

  task automatic test_vld(input logic [7:0] base, input logic [31:0] data, input logic [1:0] d);
    int lat;
    logic [39:0] st;
    for (int i = 0; i < 4; i++) poke(1, 8'(base + 8'(i)), {24'h0, data[8*i +: 8]});
    poke(2, 8'h00, {24'h0, base});
    dst = d;
    run_op(T_VLD, 0, lat, st);
    checks++;
    if (vrf[d] !== data || r2 !== 8'(base + 8'd4)) begin
      errors++;
      $display("FAIL vld_result: got vrf=%h r2=%h, required vrf=%h r2=%h", vrf[d], r2, data, 8'(base + 8'd4));
    end
    checks++;
    if (lat != exp_lat(T_VLD) || st !== exp_strobes(T_VLD)) begin
      errors++;
      $display("FAIL vld_timing: got lat=%0d strobes=%h, required lat=%0d strobes=%h", lat, st, exp_lat(T_VLD), exp_strobes(T_VLD));
    end
  endtask

  task automatic test_vst(input logic [7:0] base, input logic [31:0] data, input logic [1:0] s);
    int lat;
    logic [39:0] st;
    logic [31:0] got;
    poke(3, {6'd0, s}, data);
    poke(2, 8'h00, {24'h0, base});
    src1 = s;
    run_op(T_VST, 0, lat, st);
    for (int i = 0; i < 4; i++) got[8*i +: 8] = mem[8'(base + 8'(i))];
    checks++;
    if (got !== data || r2 !== 8'(base + 8'd4)) begin
      errors++;
      $display("FAIL vst_result: got mem=%h r2=%h, required mem=%h r2=%h", got, r2, data, 8'(base + 8'd4));
    end
    checks++;
    if (lat != exp_lat(T_VST) || st !== exp_strobes(T_VST)) begin
      errors++;
      $display("FAIL vst_timing: got lat=%0d strobes=%h, required lat=%0d strobes=%h", lat, st, exp_lat(T_VST), exp_strobes(T_VST));
    end
  endtask

  task automatic test_vadd(input logic [31:0] a, input logic [31:0] b, input logic [1:0] s,
                           input logic [1:0] d, input int repulse_at);
    int lat;
    logic [39:0] st;
    logic [31:0] exp;
    for (int i = 0; i < 4; i++) exp[8*i +: 8] = 8'((a[8*i +: 8] + b[8*i +: 8]) % 256);
    poke(3, {6'd0, s}, a);
    poke(3, {6'd0, 2'(s + 2'd1)}, b);
    src1 = s;
    src2 = 2'(s + 2'd1);
    dst  = d;
    run_op(T_VADD, repulse_at, lat, st);
    checks++;
    if (vrf[d] !== exp) begin
      errors++;
      $display("FAIL vadd_result: got %h, required %h", vrf[d], exp);
    end
    checks++;
    if (lat != exp_lat(T_VADD) || st !== exp_strobes(T_VADD)) begin
      errors++;
      $display("FAIL vadd_timing: got lat=%0d strobes=%h, required lat=%0d strobes=%h", lat, st, exp_lat(T_VADD), exp_strobes(T_VADD));
    end
  endtask

  task automatic test_illegal();
    int lat;
    logic [39:0] st;
    run_op(T_ILL, 0, lat, st);
    checks++;
    if (lat != exp_lat(T_ILL) || st !== exp_strobes(T_ILL)) begin
      errors++;
      $display("FAIL illegal_op: got lat=%0d strobes=%h, required lat=%0d strobes=%h", lat, st, exp_lat(T_ILL), exp_strobes(T_ILL));
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [39:0] st;
    int dn0;
    dn0 = dn_cnt;
    test_vadd(32'h11223344, 32'h01020304, 2'd0, 2'd3, 2);
    poke(2, 8'h00, 32'h80);
    dst = 2'd1;
    run_op(T_VLD, 3, lat, st);
    checks++;
    if (dn_cnt - dn0 != 2) begin
      errors++;
      $display("FAIL restart_done_count: got %0d, required 2", dn_cnt - dn0);
    end
  endtask

  task automatic test_invariants();
    checks++;
    if (both_cnt != 0) begin
      errors++;
      $display("FAIL rd_wr_overlap: got %0d cycles, required 0", both_cnt);
    end
    checks++;
    if (memin_bad != 0 || addr_bad != 0) begin
      errors++;
      $display("FAIL idle_mux_selects: got mem_in bad=%0d addr_sel bad=%0d, required 0/0", memin_bad, addr_bad);
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = T_VLD;
    tick();
    tick();
    test_reset();
    test_vld(8'h10, 32'h44332211, 2'd2);
    test_vst(8'hFE, 32'hDEADBEEF, 2'd1);
    test_vadd(32'h01FF7F80, 32'h01010101, 2'd0, 2'd3, 0);
    test_illegal();
    for (int i = 0; i < 4; i++) begin
      test_vld(8'($urandom), $urandom, 2'($urandom));
      test_vst(8'($urandom), $urandom, 2'($urandom));
      test_vadd($urandom, $urandom, 2'($urandom), 2'($urandom), 0);
    end
    test_back_to_back();
    test_illegal();
    test_invariants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
